// File: rtl/bht_predictor.sv
// Bimodal branch history table of saturating counters, one-cycle lookup.
// Define BHT_GSHARE_EN to XOR a global history register into the index.
module bht_predictor #(
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_req,
  input  logic [31:0]       pred_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [CNT_W-1:0]  pred_ctr,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic              upd_mispred,
  output logic [31:0]       mispred_cnt
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] CTR_MAX  = '1;
  localparam logic [CNT_W-1:0] CTR_INIT = {1'b0, {(CNT_W-1){1'b1}}};

  logic [CNT_W-1:0]   tbl_q [DEPTH];
  logic [CNT_W-1:0]   tbl_d [DEPTH];
  logic               pred_valid_q, pred_valid_d;
  logic               pred_taken_q, pred_taken_d;
  logic [CNT_W-1:0]   pred_ctr_q, pred_ctr_d;
  logic [31:0]        mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_W-1:0] pred_idx;
  logic [INDEX_W-1:0] upd_idx;
  logic [CNT_W-1:0]   upd_cur;
  logic [CNT_W-1:0]   upd_new;
  logic [CNT_W-1:0]   pred_raw;

  wire unused_pc_bits = ^{pred_pc[31:INDEX_W+2], pred_pc[1:0],
                          upd_pc[31:INDEX_W+2], upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
  logic [HIST_W-1:0] hist_q, hist_d;

  // Both ports see the history from before this cycle's shift.
  assign pred_idx = pred_pc[INDEX_W+1:2] ^ INDEX_W'(hist_q);
  assign upd_idx  = upd_pc[INDEX_W+1:2] ^ INDEX_W'(hist_q);

  always_comb begin
    hist_d = hist_q;
    if (upd_en) hist_d = (hist_q << 1) | HIST_W'(upd_taken);
  end

  always_ff @(posedge clk) begin
    if (!rst) hist_q <= '0;
    else      hist_q <= hist_d;
  end
`else
  assign pred_idx = pred_pc[INDEX_W+1:2];
  assign upd_idx  = upd_pc[INDEX_W+1:2];
`endif

  assign upd_cur = tbl_q[upd_idx];

  always_comb begin
    upd_new = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CTR_MAX) upd_new = upd_cur + CNT_W'(1);
    end else begin
      if (upd_cur != '0) upd_new = upd_cur - CNT_W'(1);
    end
  end

  // Write-first: a colliding update is visible to the lookup.
  always_comb begin
    pred_raw = tbl_q[pred_idx];
    if (upd_en && (upd_idx == pred_idx)) pred_raw = upd_new;
  end

  always_comb begin
    tbl_d = tbl_q;
    if (upd_en) tbl_d[upd_idx] = upd_new;
  end

  always_comb begin
    pred_valid_d = pred_req;
    pred_ctr_d   = pred_ctr_q;
    pred_taken_d = pred_taken_q;
    if (pred_req) begin
      pred_ctr_d   = pred_raw;
      pred_taken_d = pred_raw[CNT_W-1];
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (upd_en && upd_mispred && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CTR_INIT;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_ctr_q    <= '0;
      mispred_cnt_q <= '0;
    end else begin
      tbl_q         <= tbl_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_ctr_q    <= pred_ctr_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_ctr    = pred_ctr_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed scenarios plus random traffic
// checked against an array-based model of the counter table.
module tb_bht_predictor;

  localparam int INDEX_W = 6;
  localparam int CNT_W   = 2;
  localparam int HIST_W  = 6;
  localparam int DEPTH   = 1 << INDEX_W;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CINIT   = (1 << (CNT_W - 1)) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pred_req = 1'b0;
  logic [31:0]      pred_pc = '0;
  logic             pred_valid;
  logic             pred_taken;
  logic [CNT_W-1:0] pred_ctr;
  logic             upd_en = 1'b0;
  logic [31:0]      upd_pc = '0;
  logic             upd_taken = 1'b0;
  logic             upd_mispred = 1'b0;
  logic [31:0]      mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_tbl [DEPTH];
  int          m_hist = 0;
  logic        m_valid = 1'b0;
  logic        m_taken = 1'b0;
  int          m_ctr = 0;
  logic [31:0] m_mis = '0;

  bht_predictor #(
    .INDEX_W(INDEX_W), .CNT_W(CNT_W), .HIST_W(HIST_W)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_index(input logic [31:0] pc);
    int base;
    base = int'((pc >> 2) % DEPTH);
`ifdef BHT_GSHARE_EN
    return base ^ m_hist;
`else
    return base;
`endif
  endfunction

  // One clock: drive, let the edge happen, advance the model, settle.
  task automatic step(input logic r, input logic rq, input logic [31:0] pc,
                      input logic ue, input logic [31:0] upc,
                      input logic ut, input logic um);
    int pi, ui;
    rst = r; pred_req = rq; pred_pc = pc;
    upd_en = ue; upd_pc = upc; upd_taken = ut; upd_mispred = um;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = CINIT;
      m_valid = 0; m_taken = 0; m_ctr = 0; m_mis = 0; m_hist = 0;
    end else begin
      pi = m_index(pc);
      ui = m_index(upc);
      if (ue) begin
        if (ut) m_tbl[ui] = (m_tbl[ui] + 1 > CMAX) ? CMAX : m_tbl[ui] + 1;
        else    m_tbl[ui] = (m_tbl[ui] - 1 < 0) ? 0 : m_tbl[ui] - 1;
      end
      m_valid = rq;
      if (rq) begin
        m_ctr   = m_tbl[pi];
        m_taken = (m_ctr >= (1 << (CNT_W - 1)));
      end
      if (ue && um && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      if (ue) m_hist = ((m_hist << 1) | int'(ut)) % (1 << HIST_W);
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input logic t);
    step(1, 0, 0, 1, pc, t, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", pred_valid); end
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %0b want 0", pred_taken); end
    n_checks++; if (pred_ctr !== 2'd0) begin n_fail++; $display("FAIL rst_ctr: got %0d want 0", pred_ctr); end
    n_checks++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_mis: got %0d want 0", mispred_cnt); end
    lookup(32'h100);
    n_checks++; if (pred_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %0b want 1", pred_valid); end
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL first_taken: got %0b want 0", pred_taken); end
    n_checks++; if (pred_ctr !== 2'd1) begin n_fail++; $display("FAIL first_ctr: got %0d want 1", pred_ctr); end
  endtask

  task automatic test_saturate();
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) update(32'h100, 1);
    lookup(32'h100);
    n_checks++; if (pred_ctr !== 2'd3) begin n_fail++; $display("FAIL sat_up_ctr: got %0d want 3", pred_ctr); end
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_up_taken: got %0b want 1", pred_taken); end
    update(32'h100, 1);
    lookup(32'h100);
    n_checks++; if (pred_ctr !== 2'd3) begin n_fail++; $display("FAIL sat_hold_hi: got %0d want 3", pred_ctr); end
    repeat (5) update(32'h100, 0);
    lookup(32'h100);
    n_checks++; if (pred_ctr !== 2'd0) begin n_fail++; $display("FAIL sat_lo_ctr: got %0d want 0", pred_ctr); end
    n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_lo_taken: got %0b want 0", pred_taken); end
  endtask

  task automatic test_bypass();
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h204, 1, 32'h204, 1, 0);
    n_checks++; if (pred_ctr !== 2'd2) begin n_fail++; $display("FAIL byp_ctr: got %0d want 2", pred_ctr); end
    n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL byp_taken: got %0b want 1", pred_taken); end
    lookup(32'h208);
    n_checks++; if (pred_ctr !== 2'd1) begin n_fail++; $display("FAIL other_idx: got %0d want 1", pred_ctr); end
    idle();
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %0b want 0", pred_valid); end
    n_checks++; if (pred_ctr !== 2'd1) begin n_fail++; $display("FAIL idle_hold: got %0d want 1", pred_ctr); end
    step(1, 1, 32'h208, 1, 32'h20C, 1, 0);
    n_checks++; if (pred_ctr !== 2'd1) begin n_fail++; $display("FAIL indep_look: got %0d want 1", pred_ctr); end
    lookup(32'h20C);
    n_checks++; if (pred_ctr !== 2'd2) begin n_fail++; $display("FAIL indep_upd: got %0d want 2", pred_ctr); end
  endtask

  task automatic test_alias();
    step(0, 0, 0, 0, 0, 0, 0);
    update(32'h000, 1);
    lookup(32'h100);
    n_checks++; if (pred_ctr !== 2'd2) begin n_fail++; $display("FAIL alias_hi: got %0d want 2", pred_ctr); end
    lookup(32'hFFFF_FF03);
    n_checks++; if (pred_ctr !== 2'd2) begin n_fail++; $display("FAIL alias_low: got %0d want 2", pred_ctr); end
  endtask

  task automatic test_mispred();
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 1, 32'h300, 0, 1);
    repeat (2) step(1, 0, 0, 0, 32'h300, 1, 1);
    n_checks++; if (mispred_cnt !== 32'd4) begin n_fail++; $display("FAIL mis_cnt: got %0d want 4", mispred_cnt); end
    step(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL mis_rst: got %0d want 0", mispred_cnt); end
    lookup(32'h300);
    n_checks++; if (pred_ctr !== 2'd1) begin n_fail++; $display("FAIL mis_tbl_rst: got %0d want 1", pred_ctr); end
  endtask

  task automatic test_reset_priority();
    step(0, 0, 0, 0, 0, 0, 0);
    lookup(32'h100);
    step(0, 1, 32'h100, 1, 32'h100, 1, 1);
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL prio_valid: got %0b want 0", pred_valid); end
    n_checks++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL prio_mis: got %0d want 0", mispred_cnt); end
    idle();
    n_checks++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL prio_after: got %0b want 0", pred_valid); end
    lookup(32'h100);
    n_checks++; if (pred_ctr !== 2'd1) begin n_fail++; $display("FAIL prio_ctr: got %0d want 1", pred_ctr); end
  endtask

  task automatic test_random();
    logic [31:0] pc, upc;
    int errs_before;
    step(0, 0, 0, 0, 0, 0, 0);
    errs_before = n_fail;
    for (int i = 0; i < 400; i++) begin
      pc  = {$urandom, 2'b00} ^ {24'h0, 3'($urandom_range(0, 7)), 5'($urandom)};
      upc = {$urandom, 2'b00} ^ {24'h0, 3'($urandom_range(0, 7)), 5'($urandom)};
      pc[7:5]  = 3'b000;
      upc[7:5] = 3'b000;
      step(1, 1'($urandom), pc, 1'($urandom), upc, 1'($urandom), 1'($urandom));
      n_checks++; if (pred_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %0b want %0b", i, pred_valid, m_valid); end
      n_checks++; if (pred_ctr !== CNT_W'(m_ctr)) begin n_fail++; $display("FAIL rnd_ctr @%0d: got %0d want %0d", i, pred_ctr, m_ctr); end
      n_checks++; if (pred_taken !== m_taken) begin n_fail++; $display("FAIL rnd_taken @%0d: got %0b want %0b", i, pred_taken, m_taken); end
      n_checks++; if (mispred_cnt !== m_mis) begin n_fail++; $display("FAIL rnd_mis @%0d: got %0d want %0d", i, mispred_cnt, m_mis); end
      if (n_fail - errs_before > 20) break;
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_bypass();
    test_alias();
    test_mispred();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
